// File: rtl/permute_control.sv
// Sequencing FSM for the Keccak permute datapath: absorbs rate blocks, runs
// NUM_ROUNDS-round permutations, squeezes rate blocks, and shadows round_done.
module permute_control #(
  parameter int NUM_ROUNDS = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic       copy_control_regs_en,
  output logic       absorb_enable,
  output logic       round_en,
  output logic       state_clear,
  input  logic       round_done,
  input  logic       last_output_block,
  output logic       out_valid,
  output logic       out_last,
  input  logic       out_ready,
  output logic       output_count_en,
  output logic       busy,
  output logic       protocol_error,
  output logic [1:0] dbg_state
);

  localparam int RW = $clog2(NUM_ROUNDS);
  localparam logic [RW-1:0] RLAST = RW'(NUM_ROUNDS - 1);

  typedef enum logic [1:0] {IDLE, PERMUTE, WAIT_IN, SQUEEZE} state_e;
  typedef enum logic {PH_ABSORB, PH_SQUEEZE} phase_e;

  state_e        state_q;
  phase_e        phase_q;
  logic          last_in_q;
  logic [RW-1:0] rcnt_q;
  logic          perr_q;

  logic accept;
  logic round_mis;

  // Handshakes: a block moves when valid and ready are both high in the same
  // cycle; valid never depends on ready, and ready is only raised while idle
  // or waiting for the next absorb block.
  always_comb begin
    in_ready             = 1'b0;
    copy_control_regs_en = 1'b0;
    absorb_enable        = 1'b0;
    round_en             = 1'b0;
    state_clear          = 1'b0;
    out_valid            = 1'b0;
    out_last             = 1'b0;
    output_count_en      = 1'b0;
    busy                 = 1'b0;
    protocol_error       = 1'b0;
    dbg_state            = 2'b00;
    accept               = 1'b0;
    if (!rst) begin
      busy           = (state_q != IDLE);
      protocol_error = perr_q;
      dbg_state      = state_q;
      case (state_q)
        IDLE: begin
          in_ready             = 1'b1;
          accept               = in_valid;
          copy_control_regs_en = in_valid;
          absorb_enable        = in_valid;
          round_en             = in_valid;
          state_clear          = !in_valid;
        end
        PERMUTE: begin
          round_en = 1'b1;
        end
        WAIT_IN: begin
          in_ready      = 1'b1;
          accept        = in_valid;
          absorb_enable = in_valid;
          round_en      = in_valid;
        end
        SQUEEZE: begin
          out_valid       = 1'b1;
          out_last        = last_output_block;
          output_count_en = out_ready;
          round_en        = out_ready && !last_output_block;
        end
        default: ;
      endcase
    end
  end

  // rcnt_q is the index of the round being applied, so the datapath must flag
  // its last round exactly when the shadow count reaches NUM_ROUNDS-1.
  assign round_mis = round_en && (round_done != (rcnt_q == RLAST));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      phase_q   <= PH_ABSORB;
      last_in_q <= 1'b0;
      rcnt_q    <= '0;
      perr_q    <= 1'b0;
    end else begin
      if (round_mis) perr_q <= 1'b1;
      case (state_q)
        IDLE, WAIT_IN: begin
          if (accept) begin
            last_in_q <= in_last;
            rcnt_q    <= RW'(1);
            state_q   <= PERMUTE;
            if (state_q == IDLE) phase_q <= PH_ABSORB;
          end
        end
        PERMUTE: begin
          if (rcnt_q == RLAST) begin
            rcnt_q <= '0;
            if (phase_q == PH_ABSORB && !last_in_q) begin
              state_q <= WAIT_IN;
            end else begin
              phase_q <= PH_SQUEEZE;
              state_q <= SQUEEZE;
            end
          end else begin
            rcnt_q <= rcnt_q + RW'(1);
          end
        end
        SQUEEZE: begin
          if (out_ready) begin
            if (last_output_block) begin
              state_q <= IDLE;
            end else begin
              rcnt_q  <= RW'(1);
              state_q <= PERMUTE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/permute_control.md
# permute_control

Sequencing FSM for the Keccak permute datapath in the SHAKE pipeline. It accepts rate blocks from the padding/load stage over a valid/ready handshake and drives the datapath's `copy_control_regs_en`, `absorb_enable` and `round_en` strobes through 24-round permutations. It then presents squeezed rate blocks to the output stage over a second valid/ready handshake. A shadow round counter cross-checks the datapath's `round_done` and raises a sticky protocol error on mismatch.

## Interface
Parameters:
- `NUM_ROUNDS`, 24, rounds per permutation; must be ≥2.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset; one clock, synchronous, active-high.
- `in_valid`  in  1  previous stage holds a rate block on `rate_input`.
- `in_last`  in  1  qualifies `in_valid`; block is the final absorb block of the message.
- `in_ready`  out  1  controller accepts the block this cycle.
- `copy_control_regs_en`  out  1  datapath latches `operation_mode_in` and `output_size_in`.
- `absorb_enable`  out  1  datapath XORs `rate_input` into the round input.
- `round_en`  out  1  datapath applies one round and advances its round counter.
- `state_clear`  out  1  datapath zeroes its state register.
- `round_done`  in  1  datapath round counter is on its last round; checked only.
- `last_output_block`  in  1  datapath output-size counter says the current squeeze block is the final one.
- `out_valid`  out  1  `rate_output` holds a valid squeezed block.
- `out_last`  out  1  qualifies `out_valid`; equals `last_output_block`.
- `out_ready`  in  1  next stage takes the block.
- `output_count_en`  out  1  decrements the datapath output-size counter.
- `busy`  out  1  state ≠ IDLE.
- `protocol_error`  out  1  sticky; round_done mismatch detected.

## Operation
- States: IDLE, PERMUTE, WAIT_IN, SQUEEZE.
- Internal registers:
  - `phase`: ABSORB or SQUEEZE.
  - `last_in_reg`: last absorb block seen.
  - `rcnt`: shadow round count, range 0..NUM_ROUNDS-1.
- IDLE:
  - `in_ready`=1. `state_clear`=1 unless a block is accepted this cycle.
  - On accept (`in_valid`&`in_ready`), assert `copy_control_regs_en`, `absorb_enable` and `round_en`.
  - On accept, latch `in_last`, set `phase`=ABSORB, set `rcnt`=1, go to PERMUTE.
- PERMUTE:
  - `round_en`=1 every cycle; `rcnt` increments.
  - When `rcnt`==NUM_ROUNDS-1, the round is the last one; `rcnt` returns to 0.
  - After the last round: if `phase`=ABSORB and !`last_in_reg`, go to WAIT_IN. Otherwise set `phase`=SQUEEZE and go to SQUEEZE.
- WAIT_IN:
  - `in_ready`=1.
  - On accept, assert `absorb_enable` and `round_en`, latch `in_last`, set `rcnt`=1, go to PERMUTE.
  - `copy_control_regs_en` is not asserted in this state.
- SQUEEZE:
  - `out_valid`=1, `out_last`=`last_output_block`.
  - On `out_ready`, assert `output_count_en`.
  - If `last_output_block`, go to IDLE.
  - Otherwise assert `round_en` in the same cycle, set `rcnt`=1, go to PERMUTE. `absorb_enable`=0 for squeeze permutations.
- `absorb_enable` is only ever asserted together with `round_en` and an input accept.
- Permutation length is governed by `rcnt`, not by `round_done`.
- Check: on every `round_en` cycle, `round_done` must equal (`rcnt`==NUM_ROUNDS-1). Any mismatch sets `protocol_error`, which holds until `rst`. FSM flow is unaffected.
- `in_ready` is 0 in PERMUTE and SQUEEZE. `out_valid` is 0 outside SQUEEZE.

## Timing
- Reset: the cycle after `rst` is sampled high, state=IDLE, `phase`=ABSORB, `rcnt`=0, `last_in_reg`=0, `protocol_error`=0.
- While `rst` is high, all outputs are 0 (`in_ready` and `state_clear` gated by !`rst`).
- Reset mid-permutation or mid-squeeze aborts at once; no block is emitted. The datapath shares `rst`.
- Rounds: the first round executes on the accept/handshake cycle. Rounds 2..NUM_ROUNDS execute on the NUM_ROUNDS-1 following PERMUTE cycles.
- Latency: accept of the final absorb block at cycle t gives `out_valid`=1 at t+NUM_ROUNDS.
- Squeeze-to-squeeze: handshake at cycle s gives the next `out_valid` at s+NUM_ROUNDS.
- Back-pressure: `out_valid`, `out_last` and datapath state hold while `out_ready`=0; `round_en`=0.
- WAIT_IN can last any number of cycles; the datapath state holds and `state_clear`=0.
- Single-block message (`in_last`=1 on first accept) goes directly to SQUEEZE after one permutation.
- `in_last` outside an accept cycle is ignored. `out_ready` outside SQUEEZE is ignored.

## Test plan
- Single block, single output: IDLE accept at cycle 0 with `in_last`=1 and `last_output_block`=1 → `round_en`=1 on cycles 0–23; `out_valid`=`out_last`=1 at cycle 24; `out_ready` at 24 → IDLE with `in_ready`=1 at cycle 25; `protocol_error`=0.
- Three-block absorb with a 5-cycle input gap before block 2 → `copy_control_regs_en` only on block 1; exactly 3×24 `round_en` cycles; `absorb_enable` on exactly 3 cycles; first `out_valid` 24 cycles after block-3 accept.
- Multi-block squeeze: `last_output_block`=0 then 1 → two output handshakes 24 cycles apart; `output_count_en` pulses twice; `out_last` only on the second.
- Back-pressure: `out_ready` low for 7 cycles in SQUEEZE → `out_valid` stays 1; `round_en`, `output_count_en` and `in_ready` stay 0; completes on the 8th cycle.
- Reset at round 10 of a permutation → next cycle state IDLE, `busy`=0, `in_ready`=1; a new message then runs normally with a 24-cycle latency.
- `round_done` forced high at `rcnt`=5 → `protocol_error`=1 from the next cycle and held through the remaining message; `out_valid` still at cycle 24; cleared only by `rst`.
